hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
Feedback side of the 5-stage PA-RISC pipeline. It produces the upstream controls the fetch/decode front end consumes: LE (PC back/front and IF/ID load enable) and S (CU_MUX bubble select). It also produces operand-forwarding selects and the IF/ID flush. It keeps a shadow copy of the destination-register fields travelling through EX/MEM/WB, detects load-use and branch hazards, and sequences stalls and flushes.

Parameters:
REG_AW, 5, register-address width (32 GRs; GR0 hardwired zero)
FLUSH_CYC, 2, bubbles inserted after a taken branch resolves in EX
CNT_W, 16, width of saturating stall/flush event counters

Ports:
Clk  in  1  pipeline clock
Rst  in  1  synchronous reset, active-low
id_rs1  in  REG_AW  decode-stage source register 1
id_rs2  in  REG_AW  decode-stage source register 2
id_use_rs1  in  1  instruction in ID reads rs1
id_use_rs2  in  1  instruction in ID reads rs2
id_rd  in  REG_AW  decode-stage destination (per ID_SR/SRD selection)
id_rf_le  in  1  RF_LE from CONTROL_UNIT (pre-mux)
id_load  in  1  L from CONTROL_UNIT (pre-mux)
ex_branch_taken  in  1  branch/UB resolved taken in EX this cycle
LE  out  1  PC and IF/ID load enable
S  out  1  CU_MUX select; 1 = inject NOP controls into ID/EX
flush_ifid  out  1  clear IF/ID to NOP at next edge
fwd_a  out  2  operand A source: 00 RF, 01 EX result, 10 MEM result (ALU or RAM dataout), 11 WB result
fwd_b  out  2  operand B source, same encoding
stall_cnt  out  CNT_W  saturating count of load-use stall cycles
flush_cnt  out  CNT_W  saturating count of branch-flush cycles

Behaviour:
- Clk is the only clock. Rst is synchronous and active-low: sampled only at the rising edge of Clk, reset active when Rst==0.
- Reset (Rst==0 at posedge): all shadow stages cleared (rd=0, wr=0, ld=0); state=RUN; flush counter=0; stall_cnt=flush_cnt=0.
- While Rst==0, outputs are forced to: LE=1, S=0, flush_ifid=0, fwd_a=fwd_b=00.
- Reset asserted mid-stall or mid-flush aborts it; the first cycle after release is RUN.
- Shadow pipe: three stage registers (EX, MEM, WB), each holding {rd, wr, ld}. Every posedge:
  - EX <= {id_rd, id_rf_le & ~S & (id_rd!=0), id_load & ~S}
  - MEM <= EX; WB <= MEM.
  - The shadow pipe is never frozen, matching the ID/EX, EX/MEM and MEM/WB registers, which have no LE.
- Forwarding, combinational from the shadow registers and id_rs*:
  - If use_rsX==0 or rsX==0 -> 00.
  - Else the first match in priority order wins: EX.wr & ~EX.ld -> 01; MEM.wr -> 10; WB.wr -> 11; none -> 00.
- Load-use hazard (lu): EX.wr & EX.ld & ((use_rs1 & rs1==EX.rd) | (use_rs2 & rs2==EX.rd)).
- FSM states are RUN, STALL, FLUSH.
  - RUN:
    - If ex_branch_taken: go to FLUSH and load counter=FLUSH_CYC-1. Branch wins over a simultaneous lu.
    - Else if lu: go to STALL.
    - Outputs in RUN: LE=~lu, S=lu, flush_ifid=0. When ex_branch_taken: LE=1, S=1, flush_ifid=1.
  - STALL: exactly one cycle. The load is now in MEM and is forwarded with 10.
    - Outputs: LE=1, S=0.
    - Next state is RUN, or FLUSH if ex_branch_taken.
  - FLUSH: LE=1, S=1, flush_ifid=1.
    - Counter decrements each cycle; go to RUN when it reaches 0.
    - A new ex_branch_taken during FLUSH is ignored, because only bubbles occupy EX.
- Counters: stall_cnt increments on every cycle with S=1 caused by lu. flush_cnt increments on every cycle with flush_ifid=1. Both hold at all-ones; neither wraps.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF/FWD_EX/FWD_MEM/FWD_WB encodings
  - state encodings RUN/STALL/FLUSH
  - shadow-stage record layout {rd, wr, ld}
- One sub-module, hazard_shadow_pipe: the three-stage {rd,wr,ld} register chain with synchronous active-low clear. The FSM, forward compare and counters live in the top.

Test Plan:
- Rst=0 for 2 cycles, random inputs -> LE=1, S=0, flush_ifid=0, fwd=00, counters 0; first post-reset cycle is RUN.
- ADD r3 then ADD r5,r3,r4 (id_rd=3, rf_le=1, ld=0; next id_rs1=3) -> fwd_a=01, LE=1, S=0; with one unrelated instruction between -> fwd_a=10; with two between -> fwd_a=11.
- LDW r7 then a use of r7 as rs2 -> one cycle LE=0, S=1, stall_cnt=1; next cycle fwd_b=10, LE=1.
- Write to r0 followed by a read of r0 -> fwd=00, no stall.
- ex_branch_taken=1 in RUN -> flush_ifid=1 and S=1 for exactly 2 cycles (FLUSH_CYC=2), flush_cnt=2; ex_branch_taken concurrent with lu -> flush, no stall, stall_cnt unchanged.
- Rst=0 in the middle of FLUSH -> next cycle RUN, flush_ifid=0; force stall_cnt to all-ones and trigger lu -> count holds at 0xFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings and the shadow-stage record for the hazard/forwarding unit.
package hazard_pkg;

  localparam int unsigned RF_AW = 5;
  localparam int unsigned FWD_W = 2;

  typedef logic [FWD_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_EX  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  // Destination record carried alongside each downstream pipeline stage.
  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic             wr;
    logic             ld;
  } shadow_t;

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Three-stage EX/MEM/WB chain of destination records; never frozen.
module hazard_shadow_pipe
  import hazard_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  shadow_t ex_in,
  output shadow_t ex,
  output shadow_t mem,
  output shadow_t wb
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      ex  <= ex_in;
      mem <= ex;
      wb  <= mem;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use/branch hazard sequencing, operand-forward selects and event counters
// for the 5-stage pipeline front end.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW    = RF_AW,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rf_le,
  input  logic              id_load,
  input  logic              ex_branch_taken,
  output logic              LE,
  output logic              S,
  output logic              flush_ifid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned FC_W = $clog2(FLUSH_CYC + 1);

  state_t           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             le_c, s_c, flush_c, lu_stall_c;
  logic             lu_c;
  shadow_t          ex_in, sh_ex, sh_mem, sh_wb;

  // Bubbled or r0-targeted instructions must never look like producers.
  always_comb begin
    ex_in    = '0;
    ex_in.rd = id_rd;
    ex_in.wr = id_rf_le & ~s_c & (id_rd != '0);
    ex_in.ld = id_load & ~s_c;
  end

  hazard_shadow_pipe u_shadow (
    .clk   (Clk),
    .rst_n (Rst),
    .ex_in (ex_in),
    .ex    (sh_ex),
    .mem   (sh_mem),
    .wb    (sh_wb)
  );

  // Youngest producer wins; a load still in EX has no data yet.
  function automatic fwd_sel_t fwd_pick(input logic use_rs, input logic [REG_AW-1:0] rs,
                                        input shadow_t ex, input shadow_t mem,
                                        input shadow_t wb);
    if (!use_rs || rs == '0)                  return FWD_RF;
    if (ex.wr && !ex.ld && ex.rd == rs)       return FWD_EX;
    if (mem.wr && mem.rd == rs)               return FWD_MEM;
    if (wb.wr && wb.rd == rs)                 return FWD_WB;
    return FWD_RF;
  endfunction

  assign lu_c = sh_ex.wr & sh_ex.ld &
                ((id_use_rs1 & (id_rs1 == sh_ex.rd)) | (id_use_rs2 & (id_rs2 == sh_ex.rd)));

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    le_c       = 1'b1;
    s_c        = 1'b0;
    flush_c    = 1'b0;
    lu_stall_c = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          s_c     = 1'b1;
          flush_c = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYC - 1);
          end
        end else if (lu_c) begin
          le_c       = 1'b0;
          s_c        = 1'b1;
          lu_stall_c = 1'b1;
          state_d    = STALL;
        end
      end
      STALL: begin
        if (ex_branch_taken) begin
          state_d = FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYC);
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        s_c     = 1'b1;
        flush_c = 1'b1;
        fcnt_d  = fcnt_q - FC_W'(1);
        if (fcnt_q <= FC_W'(1)) begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    endcase
    if (!Rst) begin
      le_c       = 1'b1;
      s_c        = 1'b0;
      flush_c    = 1'b0;
      lu_stall_c = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (lu_stall_c && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (flush_c && flush_q != '1)    flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign LE         = le_c;
  assign S          = s_c;
  assign flush_ifid = flush_c;
  assign fwd_a      = Rst ? fwd_pick(id_use_rs1, id_rs1, sh_ex, sh_mem, sh_wb) : FWD_RF;
  assign fwd_b      = Rst ? fwd_pick(id_use_rs2, id_rs2, sh_ex, sh_mem, sh_wb) : FWD_RF;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;

endmodule
